// File: rtl/stream_mux_arb.sv
// stream_mux_arb
// N-channel valid/ready stream multiplexer with one registered output slot.
// Arbitration modes: explicit key (mode 00/11), round-robin (01) and
// fixed priority where the lowest index wins (10). The winning beat and
// its channel index are captured into the output register.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       arbitration mode
//   key        channel selected in key mode
//   in_data    packed channel data, channel n at [DATA_LEN*(n+1)-1 : DATA_LEN*n]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit high)
//   out_data   registered output beat
//   out_ch     index of the channel that produced out_data
//   out_valid  output beat valid
//   out_ready  consumer ready
//   err        sticky flag: key mode with an out-of-range key while any input is valid
module stream_mux_arb #(
    parameter int NR_CH    = 4,
    parameter int DATA_LEN = 2,
    parameter int SEL_LEN  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                mode,
    input  logic [SEL_LEN-1:0]        key,
    input  logic [NR_CH*DATA_LEN-1:0] in_data,
    input  logic [NR_CH-1:0]          in_valid,
    output logic [NR_CH-1:0]          in_ready,
    output logic [DATA_LEN-1:0]       out_data,
    output logic [SEL_LEN-1:0]        out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      err
);

    localparam logic [SEL_LEN-1:0] LAST_CH = SEL_LEN'(NR_CH - 1);
    // One extra bit so NR_CH itself is representable for the range check.
    localparam logic [SEL_LEN:0]   NR_CH_W = (SEL_LEN + 1)'(NR_CH);

    logic [DATA_LEN-1:0] out_data_r;
    logic [SEL_LEN-1:0]  out_ch_r;
    logic                out_valid_r;
    logic                err_r;
    logic [SEL_LEN-1:0]  rr_ptr_r;

    logic                key_mode_s;
    logic                key_in_range_s;
    logic                can_load_s;
    logic                grant_valid_s;
    logic [SEL_LEN-1:0]  grant_idx_s;
    logic [SEL_LEN-1:0]  rr_cand_s;
    logic [DATA_LEN-1:0] sel_data_s;

    // Next channel in round-robin order, wrapping from the last channel to 0.
    function automatic logic [SEL_LEN-1:0] wrap_inc(input logic [SEL_LEN-1:0] ch);
        logic [SEL_LEN-1:0] nxt;
        if (ch == LAST_CH) begin
            nxt = {SEL_LEN{1'b0}};
        end else begin
            nxt = ch + {{(SEL_LEN-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // Valid bit of a channel addressed by an index; out-of-range indices read as idle.
    function automatic logic chan_valid(input logic [SEL_LEN-1:0] ch,
                                        input logic [NR_CH-1:0]   vld);
        logic v;
        v = 1'b0;
        for (int i = 0; i < NR_CH; i++) begin
            if (ch == SEL_LEN'(i)) begin
                v = vld[i];
            end else begin
                v = v;
            end
        end
        return v;
    endfunction

    assign key_mode_s     = (mode == 2'b00) || (mode == 2'b11);
    assign key_in_range_s = ({1'b0, key} < NR_CH_W);
    assign can_load_s     = !out_valid_r || out_ready;

    // Grant selection from the current mode, key, valids and round-robin pointer.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = {SEL_LEN{1'b0}};
        rr_cand_s     = wrap_inc(rr_ptr_r);
        case (mode)
            2'b01: begin
                // Walk NR_CH candidates starting just after the last winner.
                for (int i = 0; i < NR_CH; i++) begin
                    if (!grant_valid_s && chan_valid(rr_cand_s, in_valid)) begin
                        grant_valid_s = 1'b1;
                        grant_idx_s   = rr_cand_s;
                    end else begin
                        grant_valid_s = grant_valid_s;
                    end
                    rr_cand_s = wrap_inc(rr_cand_s);
                end
            end
            2'b10: begin
                // Scan downward so the lowest valid index is the last assignment.
                for (int i = NR_CH - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        grant_valid_s = 1'b1;
                        grant_idx_s   = SEL_LEN'(i);
                    end else begin
                        grant_valid_s = grant_valid_s;
                    end
                end
            end
            default: begin
                // Key modes 00 and 11: only the keyed channel may win.
                for (int i = 0; i < NR_CH; i++) begin
                    if ((key == SEL_LEN'(i)) && in_valid[i]) begin
                        grant_valid_s = 1'b1;
                        grant_idx_s   = SEL_LEN'(i);
                    end else begin
                        grant_valid_s = grant_valid_s;
                    end
                end
            end
        endcase
    end

    // Data of the granted channel and the one-hot ready back to the producers.
    always_comb begin
        sel_data_s = {DATA_LEN{1'b0}};
        in_ready   = {NR_CH{1'b0}};
        for (int i = 0; i < NR_CH; i++) begin
            if (grant_idx_s == SEL_LEN'(i)) begin
                sel_data_s  = in_data[i*DATA_LEN +: DATA_LEN];
                in_ready[i] = can_load_s && grant_valid_s;
            end else begin
                in_ready[i] = 1'b0;
            end
        end
    end

    // Output slot, round-robin pointer and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= {DATA_LEN{1'b0}};
            out_ch_r    <= {SEL_LEN{1'b0}};
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
            rr_ptr_r    <= LAST_CH;
        end else begin
            if (key_mode_s && !key_in_range_s && (|in_valid)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
            if (grant_valid_s && can_load_s) begin
                out_data_r  <= sel_data_s;
                out_ch_r    <= grant_idx_s;
                out_valid_r <= 1'b1;
                rr_ptr_r    <= grant_idx_s;
            end else if (out_valid_r && out_ready) begin
                // Beat consumed with nothing to replace it; data/ch keep their value.
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign out_valid = out_valid_r;
    assign err       = err_r;

endmodule
